wb_master_arbiter: RTL and testbench

Two-master to one-slave Wishbone (pipelined) arbiter that shares the single system bus between the UART Intel-HEX loader and a second bus master (e.g. CPU data port or debug bridge). It grants the bus for whole `cyc` cycles, routes the granted master to the slave, and stalls the other. A watchdog aborts transactions that never complete. It sits between the masters' `wishbone` interfaces and the memory/peripheral interconnect.

---
 rtl/wb_master_arbiter_pkg.sv | 20 ++
 rtl/wb_master_arbiter_if.sv | 25 ++
 rtl/wb_master_arbiter_watchdog.sv | 36 +++
 rtl/wb_master_arbiter.sv | 172 +++++++++++++++++
 tb/tb_wb_master_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_master_arbiter_pkg.sv
// Shared types and widths for the two-master Wishbone arbiter.
package wb_arb_pkg;

  localparam int unsigned WB_ARB_CNT_W = 16;
  localparam int unsigned WB_SEL_W     = 4;
  localparam int unsigned WB_ADDR_W    = 30;
  localparam int unsigned WB_DATA_W    = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    ABORT  = 2'd3
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wb_master_arbiter_if.sv
// Pipelined Wishbone bus bundle; master drives the request, slave drives the response.
interface wishbone;
  import wb_arb_pkg::*;

  logic                 stb;
  logic                 cyc;
  logic [WB_SEL_W-1:0]  sel;
  logic [WB_ADDR_W-1:0] addr;
  logic [WB_DATA_W-1:0] mosi_data;
  logic                 stall;
  logic                 ack;
  logic                 err;
  logic [WB_DATA_W-1:0] miso_data;

  modport master (
    output stb, cyc, sel, addr, mosi_data,
    input  stall, ack, err, miso_data
  );

  modport slave (
    input  stb, cyc, sel, addr, mosi_data,
    output stall, ack, err, miso_data
  );

endinterface

// File: rtl/wb_master_arbiter_watchdog.sv
// Saturating idle-response counter; o_expired flags when this cycle's count reaches the limit.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [WB_ARB_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && (cnt_q != '1)) begin
      cnt_d = cnt_q + WB_ARB_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compare the updated count so the abort lands right after the last tolerated cycle.
  assign o_expired = (cnt_d >= WB_ARB_CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master to one-slave pipelined Wishbone arbiter: whole-cyc grants plus watchdog abort.
// Build option WB_ARB_ROUND_ROBIN_EN: ties go to the master not granted last; otherwise m0 wins.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       i_clk,
  input  logic       i_reset,
  wishbone.slave     m0,
  wishbone.slave     m1,
  wishbone.master    s,
  output logic [1:0] o_grant,
  output logic       o_timeout
);

  arb_state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       timeout_q, timeout_d;
  logic       tie_to_m1;
  logic       in_grant;
  logic       wd_clear;
  logic       wd_expired;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic last_m1_q, last_m1_d;

  assign tie_to_m1 = ~last_m1_q;

  // Pointer starts at "m1 last" so m0 takes the first tie.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last_m1_q <= 1'b1;
    end else begin
      last_m1_q <= last_m1_d;
    end
  end
`else
  assign tie_to_m1 = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      grant_q   <= GRANT_NONE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state; grant_q keeps the owner through ABORT so the error is routed back to it.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    timeout_d = 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
    last_m1_d = last_m1_q;
`endif
    case (state_q)
      IDLE: begin
        grant_d = GRANT_NONE;
        if (m0.cyc && !(m1.cyc && tie_to_m1)) begin
          state_d = GRANT0;
          grant_d = GRANT_M0;
`ifdef WB_ARB_ROUND_ROBIN_EN
          last_m1_d = 1'b0;
`endif
        end else if (m1.cyc) begin
          state_d = GRANT1;
          grant_d = GRANT_M1;
`ifdef WB_ARB_ROUND_ROBIN_EN
          last_m1_d = 1'b1;
`endif
        end
      end
      GRANT0: begin
        if (!m0.cyc) begin
          state_d = IDLE;
          grant_d = GRANT_NONE;
        end else if (wd_expired) begin
          state_d   = ABORT;
          timeout_d = 1'b1;
        end
      end
      GRANT1: begin
        if (!m1.cyc) begin
          state_d = IDLE;
          grant_d = GRANT_NONE;
        end else if (wd_expired) begin
          state_d   = ABORT;
          timeout_d = 1'b1;
        end
      end
      ABORT: begin
        state_d = IDLE;
        grant_d = GRANT_NONE;
      end
      default: begin
        state_d = IDLE;
        grant_d = GRANT_NONE;
      end
    endcase
  end

  // Bus routing: owner talks to the slave, everyone else is held off with stall.
  always_comb begin
    s.cyc        = 1'b0;
    s.stb        = 1'b0;
    s.sel        = '0;
    s.addr       = '0;
    s.mosi_data  = '0;
    m0.stall     = 1'b1;
    m0.ack       = 1'b0;
    m0.err       = 1'b0;
    m0.miso_data = '0;
    m1.stall     = 1'b1;
    m1.ack       = 1'b0;
    m1.err       = 1'b0;
    m1.miso_data = '0;
    case (state_q)
      GRANT0: begin
        s.cyc        = m0.cyc;
        s.stb        = m0.stb;
        s.sel        = m0.sel;
        s.addr       = m0.addr;
        s.mosi_data  = m0.mosi_data;
        m0.stall     = s.stall;
        m0.ack       = s.ack;
        m0.err       = s.err;
        m0.miso_data = s.miso_data;
      end
      GRANT1: begin
        s.cyc        = m1.cyc;
        s.stb        = m1.stb;
        s.sel        = m1.sel;
        s.addr       = m1.addr;
        s.mosi_data  = m1.mosi_data;
        m1.stall     = s.stall;
        m1.ack       = s.ack;
        m1.err       = s.err;
        m1.miso_data = s.miso_data;
      end
      ABORT: begin
        m0.err = grant_q[0];
        m1.err = grant_q[1];
      end
      default: begin
      end
    endcase
  end

  // Any slave response or accepted strobe proves the slave is alive.
  assign in_grant = (state_q == GRANT0) || (state_q == GRANT1);
  assign wd_clear = !in_grant || s.err || s.ack || (s.stb && !s.stall);

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (wd_clear),
    .i_enable  (in_grant),
    .o_expired (wd_expired)
  );

  assign o_grant   = grant_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench: directed scenarios then random traffic against a cycle-level reference model.
module tb_wb_master_arbiter;
  import wb_arb_pkg::*;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       tmo;

  wishbone m0_if ();
  wishbone m1_if ();
  wishbone s_if ();

  wb_master_arbiter #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .o_grant   (grant),
    .o_timeout (tmo)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, whether this cycle is the abort cycle, idle-response count.
  int owner;
  bit aborting;
  int wd;
`ifdef WB_ARB_ROUND_ROBIN_EN
  int last;
`endif
  int n_pass   = 0;
  int n_fail   = 0;
  int n_checks = 0;
  bit dead;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int i, input logic cyc, input logic stb, input logic [3:0] sel,
                       input logic [29:0] a, input logic [31:0] d);
    if (i == 0) begin
      m0_if.cyc = cyc; m0_if.stb = stb; m0_if.sel = sel; m0_if.addr = a; m0_if.mosi_data = d;
    end else begin
      m1_if.cyc = cyc; m1_if.stb = stb; m1_if.sel = sel; m1_if.addr = a; m1_if.mosi_data = d;
    end
  endtask

  task automatic set_s(input logic stall, input logic ack, input logic err, input logic [31:0] d);
    s_if.stall = stall; s_if.ack = ack; s_if.err = err; s_if.miso_data = d;
  endtask

  function automatic logic get_cyc(input int i);
    return (i == 0) ? m0_if.cyc : m1_if.cyc;
  endfunction

  function automatic logic get_stb(input int i);
    return (i == 0) ? m0_if.stb : m1_if.stb;
  endfunction

  function automatic logic [67:0] mreq(input int i);
    if (i == 0) return {m0_if.cyc, m0_if.stb, m0_if.sel, m0_if.addr, m0_if.mosi_data};
    return {m1_if.cyc, m1_if.stb, m1_if.sel, m1_if.addr, m1_if.mosi_data};
  endfunction

  function automatic logic [2:0] mresp(input int i);
    if (i == 0) return {m0_if.stall, m0_if.ack, m0_if.err};
    return {m1_if.stall, m1_if.ack, m1_if.err};
  endfunction

  function automatic logic [31:0] mmiso(input int i);
    return (i == 0) ? m0_if.miso_data : m1_if.miso_data;
  endfunction

  task automatic model_reset();
    owner = -1; aborting = 1'b0; wd = 0;
`ifdef WB_ARB_ROUND_ROBIN_EN
    last = 1;
`endif
  endtask

  // Compare every visible output mid-cycle against what the model says this cycle should show.
  task automatic sample();
    logic [67:0] obs_s;
    logic [1:0]  exp_g;
    @(negedge clk);
    exp_g = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    check("grant", 128'(grant), 128'(exp_g));
    check("timeout", 128'(tmo), 128'(aborting));
    obs_s = {s_if.cyc, s_if.stb, s_if.sel, s_if.addr, s_if.mosi_data};
    if (owner < 0)      check("s_idle", 128'(obs_s), 128'(0));
    else if (aborting)  check("s_abort", 128'(obs_s[67:66]), 128'(0));
    else                check("s_fwd", 128'(obs_s), 128'(mreq(owner)));
    for (int i = 0; i < 2; i++) begin
      if (owner == i && !aborting) begin
        check("m_resp", 128'(mresp(i)), 128'({s_if.stall, s_if.ack, s_if.err}));
        check("m_miso", 128'(mmiso(i)), 128'(s_if.miso_data));
      end else if (owner == i) begin
        check("m_abort", 128'(mresp(i)), 128'(3'b101));
      end else begin
        check("m_held", 128'(mresp(i)), 128'(3'b100));
      end
    end
  endtask

  // Advance the model across the clock edge using the stimulus as it stood at that edge.
  task automatic advance();
    bit c0, c1, act;
    @(posedge clk);
    c0 = get_cyc(0);
    c1 = get_cyc(1);
    if (rst) begin
      model_reset();
    end else if (aborting) begin
      aborting = 1'b0; owner = -1;
    end else if (owner < 0) begin
      if (c0 && c1) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        owner = (last == 1) ? 0 : 1;
`else
        owner = 0;
`endif
      end else if (c0) owner = 0;
      else if (c1)     owner = 1;
`ifdef WB_ARB_ROUND_ROBIN_EN
      if (owner >= 0) last = owner;
`endif
      wd = 0;
    end else if (!get_cyc(owner)) begin
      owner = -1;
    end else begin
      act = s_if.ack || s_if.err || (get_stb(owner) && !s_if.stall);
      if (act)               wd = 0;
      else if (wd < 65535)   wd = wd + 1;
      if (wd >= TO) aborting = 1'b1;
    end
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  logic [1:0] tie_exp [3];

  initial begin
    rst = 1'b1;
    set_m(0, 0, 0, 4'h0, 30'h0, 32'h0);
    set_m(1, 0, 0, 4'h0, 30'h0, 32'h0);
    set_s(0, 0, 0, 32'h0);
    model_reset();
    dead = 1'b0;
    @(posedge clk); #1;

    // Reset state
    sample();
    check("rst_grant", 128'(grant), 128'(2'b00));
    check("rst_tmo", 128'(tmo), 128'(1'b0));
    check("rst_scyc", 128'(s_if.cyc), 128'(1'b0));
    advance();
    rst = 1'b0;
    tick();

    // m0 single write, slave accepts then acks a cycle later
    set_m(0, 1, 1, 4'b1000, 30'h10, 32'hAB00_0000);
    tick();
    sample();
    check("t1_grant", 128'(grant), 128'(2'b01));
    check("t1_sel", 128'(s_if.sel), 128'(4'b1000));
    check("t1_addr", 128'(s_if.addr), 128'(30'h10));
    check("t1_data", 128'(s_if.mosi_data), 128'(32'hAB00_0000));
    check("t1_stb", 128'(s_if.stb), 128'(1'b1));
    advance();
    set_m(0, 1, 0, 4'b1000, 30'h10, 32'hAB00_0000);
    set_s(0, 1, 0, 32'hCAFE_0001);
    sample();
    check("t1_ack", 128'(m0_if.ack), 128'(1'b1));
    advance();
    set_m(0, 0, 0, 4'h0, 30'h0, 32'h0);
    set_s(0, 0, 0, 32'h0);
    tick();
    sample();
    check("t1_idle", 128'(grant), 128'(2'b00));
    advance();
    tick();

    // Simultaneous requests
    set_m(0, 1, 1, 4'hF, 30'h20, 32'h1111_1111);
    set_m(1, 1, 1, 4'h3, 30'h40, 32'h2222_2222);
    tick();
    sample();
`ifdef WB_ARB_ROUND_ROBIN_EN
    check("t2_tie", 128'(grant), 128'(2'b10));
`else
    check("t2_tie", 128'(grant), 128'(2'b01));
    check("t2_m1stall", 128'(m1_if.stall), 128'(1'b1));
`endif
    advance();
    tick();
    tick();
    set_m(0, 0, 0, 4'h0, 30'h0, 32'h0);
    set_m(1, 0, 0, 4'h0, 30'h0, 32'h0);
    tick();
    tick();

    // Handover: m0 drops cyc as m1 raises it
    set_m(0, 1, 1, 4'h1, 30'h50, 32'h5);
    tick();
    tick();
    set_m(0, 0, 0, 4'h0, 30'h0, 32'h0);
    set_m(1, 1, 1, 4'h2, 30'h60, 32'h6);
    tick();
    sample();
    check("t3_gap", 128'(grant), 128'(2'b00));
    advance();
    sample();
    check("t3_m1", 128'(grant), 128'(2'b10));
    advance();
    set_m(1, 0, 0, 4'h0, 30'h0, 32'h0);
    tick();
    tick();

    // Three identical ties
`ifdef WB_ARB_ROUND_ROBIN_EN
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01;
`else
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b01; tie_exp[2] = 2'b01;
`endif
    for (int r = 0; r < 3; r++) begin
      set_m(0, 1, 0, 4'h0, 30'h0, 32'h0);
      set_m(1, 1, 0, 4'h0, 30'h0, 32'h0);
      tick();
      sample();
      check("t4_alt", 128'(grant), 128'(tie_exp[r]));
      advance();
      set_m(0, 0, 0, 4'h0, 30'h0, 32'h0);
      set_m(1, 0, 0, 4'h0, 30'h0, 32'h0);
      tick();
      tick();
    end

    // Dead slave: watchdog abort
    set_m(0, 1, 1, 4'hF, 30'h99, 32'hDEAD_BEEF);
    set_s(1, 0, 0, 32'h0);
    tick();
    for (int k = 0; k < TO; k++) begin
      sample();
      check("t5_hold", 128'(tmo), 128'(1'b0));
      advance();
    end
    sample();
    check("t5_tmo", 128'(tmo), 128'(1'b1));
    check("t5_err", 128'(m0_if.err), 128'(1'b1));
    check("t5_scyc", 128'(s_if.cyc), 128'(1'b0));
    advance();
    set_m(0, 0, 0, 4'h0, 30'h0, 32'h0);
    set_s(0, 0, 0, 32'h0);
    sample();
    check("t5_after", 128'(tmo), 128'(1'b0));
    advance();
    tick();

    // Slave error on m1's strobe clears the watchdog
    set_m(1, 1, 1, 4'h1, 30'h7, 32'h77);
    set_s(0, 0, 1, 32'h0);
    tick();
    sample();
    check("t6_err", 128'(m1_if.err), 128'(1'b1));
    advance();
    set_m(1, 1, 0, 4'h1, 30'h7, 32'h77);
    set_s(1, 0, 0, 32'h0);
    for (int k = 0; k < TO - 2; k++) tick();
    set_m(1, 1, 1, 4'h1, 30'h8, 32'h78);
    set_s(1, 0, 1, 32'h0);
    tick();
    set_m(1, 1, 0, 4'h1, 30'h8, 32'h78);
    set_s(1, 0, 0, 32'h0);
    for (int k = 0; k < TO - 2; k++) tick();
    sample();
    check("t6_notmo", 128'(tmo), 128'(1'b0));
    advance();
    set_m(1, 0, 0, 4'h0, 30'h0, 32'h0);
    set_s(0, 0, 0, 32'h0);
    tick();
    tick();

    // Reset in the middle of an m1 burst with m0 waiting
    set_m(1, 1, 1, 4'h4, 30'h123, 32'h4444);
    tick();
    tick();
    set_m(0, 1, 1, 4'h8, 30'h321, 32'h8888);
    tick();
    rst = 1'b1;
    set_m(1, 0, 0, 4'h0, 30'h0, 32'h0);
    tick();
    rst = 1'b0;
    sample();
    check("t7_scyc", 128'(s_if.cyc), 128'(1'b0));
    check("t7_grant", 128'(grant), 128'(2'b00));
    advance();
    sample();
    check("t7_m0", 128'(grant), 128'(2'b01));
    advance();
    set_m(0, 0, 0, 4'h0, 30'h0, 32'h0);
    tick();
    tick();

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      bit c;
      if (($urandom % 50) == 0) dead = ~dead;
      for (int i = 0; i < 2; i++) begin
        c = get_cyc(i);
        if (c) c = ($urandom % 12) != 0;
        else   c = ($urandom % 4) == 0;
        set_m(i, c, c & 1'($urandom), 4'($urandom), 30'($urandom), $urandom);
      end
      if (dead) set_s(1, 0, 0, $urandom);
      else      set_s(($urandom % 3) == 0, 1'($urandom), ($urandom % 12) == 0, $urandom);
      rst = ($urandom % 150) == 0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
